// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the PHY transmit stripe serializer.
// Covers the frame geometry, the idle symbol and the configuration legality rule.
package phy_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic {
    STARTUP,
    RUN
  } tx_state_e;

  typedef struct packed {
    int unsigned p;
    int unsigned bpl;
  } frame_geom_t;

  // p is the frame length in cycles (bits per lane); bpl is the number of bytes per lane per frame.
  function automatic frame_geom_t frame_geom(int unsigned data_w, int unsigned lanes);
    frame_geom_t g;
    g.p   = data_w / lanes;
    g.bpl = data_w / (8 * lanes);
    return g;
  endfunction

  function automatic bit cfg_legal(int unsigned data_w, int unsigned lanes);
    return ((lanes == 1) || (lanes == 2) || (lanes == 4)) &&
           (data_w != 0) && ((data_w % (8 * lanes)) == 0);
  endfunction

endpackage

// File: rtl/phy_tx_lane_shifter.sv
// One serial lane: a P-bit register that loads a whole frame at a boundary,
// otherwise shifts left, and presents its MSB as the line bit.
module phy_tx_lane_shifter #(
  parameter int P = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [P-1:0] frame_i,
  output logic         bit_o
);

  logic [P-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = load_i ? frame_i : {shift_q[P-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_o = shift_q[P-1];

endmodule

// File: rtl/phy_tx_stripe_serializer.sv
// Word-to-lane transmit serializer: stripes accepted words byte-wise across LANES
// serial lanes, fills empty frames with the idle symbol and forces idles after reset.
module phy_tx_stripe_serializer
  import phy_tx_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LANES     = 2,
  parameter logic [7:0]  IDLE_BYTE = K28_5,
  parameter int          MIN_IDLE  = 4,
  parameter int          CNT_W     = 16
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANES-1:0]  data_out,
  output logic [LANES-1:0]  valid_out,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam frame_geom_t     GEOM        = frame_geom(DATA_W, LANES);
  localparam int              P           = int'(GEOM.p);
  localparam int              BPL         = int'(GEOM.bpl);
  localparam int              BC_W        = (P > 1) ? $clog2(P) : 1;
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(P - 1);
  localparam tx_state_e       RESET_STATE = (MIN_IDLE == 0) ? RUN : STARTUP;

  if (!cfg_legal(DATA_W, LANES) || (MIN_IDLE < 0) || (MIN_IDLE > 255)) begin : g_bad_cfg
    $error("phy_tx_stripe_serializer: illegal DATA_W/LANES/MIN_IDLE combination");
  end

  tx_state_e                   state_q, state_d;
  logic [BC_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]                  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
  logic [LANES-1:0]            valid_q, valid_d;
  logic                        boundary;
  logic                        xfer;
  logic [LANES-1:0][P-1:0]     lane_frame;

  assign boundary  = (bit_cnt_q == LAST_BIT);
  assign ready_out = (state_q == RUN) && boundary;
  assign xfer      = ready_out && valid_in;

  // Frame sequencing: bit counter wrap, startup idle accounting and the word counter
  // all change only on a boundary edge.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + BC_W'(1);
    idle_cnt_d = idle_cnt_q;
    word_cnt_d = word_cnt_q;
    valid_d    = valid_q;
    if (boundary) begin
      bit_cnt_d = '0;
      valid_d   = {LANES{xfer}};
      if (xfer) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      if (state_q == STARTUP) begin
        idle_cnt_d = idle_cnt_q + 8'd1;
        if (({1'b0, idle_cnt_q} + 9'd1) >= 9'(MIN_IDLE)) begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      bit_cnt_q  <= LAST_BIT;
      idle_cnt_q <= '0;
      word_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      word_cnt_q <= word_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Byte k lands on lane k%LANES in slot k/LANES; slot 0 sits in the MSBs so it leaves first.
  always_comb begin
    lane_frame = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < BPL; s++) begin
        lane_frame[l][P-1-8*s -: 8] = xfer ? data_in[DATA_W-1-8*(s*LANES+l) -: 8] : IDLE_BYTE;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    phy_tx_lane_shifter #(
      .P(P)
    ) u_shift (
      .clk_i  (clk_32f),
      .rst_i  (reset),
      .load_i (boundary),
      .frame_i(lane_frame[l]),
      .bit_o  (data_out[l])
    );
  end

  assign valid_out = valid_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_phy_tx_stripe_serializer.sv
// Self-checking bench for phy_tx_stripe_serializer: a 2-lane and a 4-lane instance
// checked every cycle against an edge-index reference model plus frame-level vectors.
module tb_phy_tx_stripe_serializer;

  typedef struct {
    bit          valid;
    logic [31:0] word;
    logic [15:0] lane0;
    logic [15:0] lane1;
    logic [1:0]  vld;
    int unsigned cnt;
  } vec_t;

  logic clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  logic        resetA = 1'b1;
  logic        validA = 1'b0;
  logic [31:0] dataA  = '0;
  logic        readyA;
  logic [1:0]  doutA, voutA;
  logic [15:0] cntA;

  logic        resetB = 1'b1;
  logic        validB = 1'b0;
  logic [31:0] dataB  = '0;
  logic        readyB;
  logic [3:0]  doutB, voutB;
  logic [3:0]  cntB;

  phy_tx_stripe_serializer #(
    .DATA_W(32), .LANES(2), .IDLE_BYTE(8'hBC), .MIN_IDLE(4), .CNT_W(16)
  ) dutA (
    .clk_32f(clk32f), .reset(resetA), .data_in(dataA), .valid_in(validA),
    .ready_out(readyA), .data_out(doutA), .valid_out(voutA), .word_cnt(cntA)
  );

  phy_tx_stripe_serializer #(
    .DATA_W(32), .LANES(4), .IDLE_BYTE(8'hBC), .MIN_IDLE(1), .CNT_W(4)
  ) dutB (
    .clk_32f(clk32f), .reset(resetB), .data_in(dataB), .valid_in(validB),
    .ready_out(readyB), .data_out(doutB), .valid_out(voutB), .word_cnt(cntB)
  );

  int vectors = 0;
  int miscompares = 0;

  int          nEdge[2];
  int          lanesOf[2] = '{2, 4};
  int          minIdle[2] = '{4, 1};
  int          cntW[2]    = '{16, 4};
  logic [31:0] mFrame[2][4];
  bit          mValid[2];
  int unsigned mCnt[2];

  logic [15:0] cap[4];
  logic [3:0]  vAnd, vOr;

  function automatic logic dutReady(int id);
    return (id == 0) ? readyA : readyB;
  endfunction

  function automatic logic [3:0] dutDout(int id);
    return (id == 0) ? {2'b00, doutA} : doutB;
  endfunction

  function automatic logic [3:0] dutVout(int id);
    return (id == 0) ? {2'b00, voutA} : voutB;
  endfunction

  function automatic logic [15:0] dutCnt(int id);
    return (id == 0) ? cntA : {12'h000, cntB};
  endfunction

  task automatic checkOutput(input string name, input int id, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s dut=%0d edge=%0d got=%h want=%h", name, id, nEdge[id], got, want);
    end
  endtask

  task automatic applyStimulus(input int id, input bit v, input logic [31:0] d);
    if (id == 0) begin
      validA = v;
      dataA  = d;
    end else begin
      validB = v;
      dataB  = d;
    end
  endtask

  task automatic modelReset(input int id);
    nEdge[id]  = 0;
    mValid[id] = 1'b0;
    mCnt[id]   = 0;
    for (int l = 0; l < 4; l++) mFrame[id][l] = '0;
  endtask

  // Edge n (1-based after release) is a frame boundary when (n-1) is a multiple of P;
  // frame index (n-1)/P decides whether the forced idle period is over.
  task automatic modelEdge(input int id);
    int          lanes, p, bpl;
    bit          v, xfer;
    logic [31:0] d;
    logic [7:0]  b;
    lanes = lanesOf[id];
    p     = 32 / lanes;
    bpl   = p / 8;
    v     = (id == 0) ? validA : validB;
    d     = (id == 0) ? dataA : dataB;
    if ((nEdge[id] % p) == 0) begin
      xfer = v && ((nEdge[id] / p) >= minIdle[id]);
      for (int l = 0; l < lanes; l++) begin
        for (int s = 0; s < bpl; s++) begin
          b = xfer ? d[31-8*(s*lanes+l) -: 8] : 8'hBC;
          mFrame[id][l][p-1-8*s -: 8] = b;
        end
      end
      mValid[id] = xfer;
      if (xfer) mCnt[id] = (mCnt[id] + 1) % (32'd1 << cntW[id]);
    end
    nEdge[id]++;
  endtask

  task automatic checkCycle(input int id);
    int         n, p, lanes;
    logic       expR;
    logic [3:0] expD, expV;
    lanes = lanesOf[id];
    p     = 32 / lanes;
    n     = nEdge[id];
    expR  = ((n % p) == 0) && ((n / p) >= minIdle[id]);
    expD  = '0;
    for (int l = 0; l < lanes; l++) begin
      expD[l] = (n == 0) ? 1'b0 : mFrame[id][l][p-1-((n-1)%p)];
    end
    expV = mValid[id] ? 4'((1 << lanes) - 1) : 4'h0;
    checkOutput("ready_out", id, 32'(dutReady(id)), 32'(expR));
    checkOutput("data_out", id, 32'(dutDout(id)), 32'(expD));
    checkOutput("valid_out", id, 32'(dutVout(id)), 32'(expV));
    checkOutput("word_cnt", id, 32'(dutCnt(id)), mCnt[id]);
  endtask

  task automatic startCapture();
    for (int l = 0; l < 4; l++) cap[l] = '0;
    vAnd = '1;
    vOr  = '0;
  endtask

  task automatic runCycle(input int id);
    logic [3:0] d, v;
    @(posedge clk32f);
    modelEdge(id);
    @(negedge clk32f);
    checkCycle(id);
    d = dutDout(id);
    v = dutVout(id);
    for (int l = 0; l < 4; l++) cap[l] = {cap[l][14:0], d[l]};
    vAnd &= v;
    vOr  |= v;
  endtask

  task automatic doReset(input int id);
    @(negedge clk32f);
    if (id == 0) resetA = 1'b1; else resetB = 1'b1;
    modelReset(id);
    @(posedge clk32f);
    @(negedge clk32f);
    checkCycle(id);
    if (id == 0) resetA = 1'b0; else resetB = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   firstReady;

    tbl[0] = '{1'b1, 32'hFFDD_FFDD, 16'hFFFF, 16'hDDDD, 2'b11, 1};
    tbl[1] = '{1'b1, 32'hDDFF_AABB, 16'hDDAA, 16'hFFBB, 2'b11, 2};
    tbl[2] = '{1'b0, 32'h0BAD_F00D, 16'hBCBC, 16'hBCBC, 2'b00, 2};
    tbl[3] = '{1'b1, 32'h1234_5678, 16'h1256, 16'h3478, 2'b11, 3};
    tbl[4] = '{1'b0, 32'h0000_0000, 16'hBCBC, 16'hBCBC, 2'b00, 3};

    modelReset(0);
    modelReset(1);

    // Startup: valid held high, ready must stay low through four idle frames.
    applyStimulus(0, 1'b1, 32'h1357_9BDF);
    doReset(0);
    firstReady = -1;
    for (int c = 1; c <= 80 && firstReady < 0; c++) begin
      runCycle(0);
      if (readyA === 1'b1) firstReady = c;
    end
    checkOutput("first_ready_cycle", 0, firstReady, 64);

    for (int r = 0; r < 5; r++) begin
      applyStimulus(0, tbl[r].valid, tbl[r].word);
      startCapture();
      repeat (16) runCycle(0);
      checkOutput("lane0_frame", 0, 32'(cap[0]), 32'(tbl[r].lane0));
      checkOutput("lane1_frame", 0, 32'(cap[1]), 32'(tbl[r].lane1));
      checkOutput("valid_all", 0, 32'(vAnd[1:0]), 32'(tbl[r].vld));
      checkOutput("valid_any", 0, 32'(vOr[1:0]), 32'(tbl[r].vld));
      checkOutput("frame_cnt", 0, 32'(cntA), tbl[r].cnt);
    end

    // valid raised mid-frame must wait for the next ready.
    applyStimulus(0, 1'b0, 32'h0);
    repeat (3) runCycle(0);
    applyStimulus(0, 1'b1, 32'hA5A5_5A5A);
    repeat (13) runCycle(0);
    checkOutput("cnt_hold", 0, 32'(cntA), 3);
    checkOutput("idle_valid", 0, 32'(voutA), 0);
    checkOutput("late_ready", 0, 32'(readyA), 1);
    runCycle(0);
    checkOutput("late_accept_cnt", 0, 32'(cntA), 4);
    repeat (5) runCycle(0);

    // Asynchronous reset in the middle of a data frame.
    #2 resetA = 1'b1;
    #1;
    checkOutput("rst_dout", 0, 32'(doutA), 0);
    checkOutput("rst_vout", 0, 32'(voutA), 0);
    checkOutput("rst_cnt", 0, 32'(cntA), 0);
    modelReset(0);
    @(negedge clk32f);
    resetA = 1'b0;
    applyStimulus(0, 1'b1, $urandom);
    repeat (64) runCycle(0);
    checkOutput("ready_after_reset", 0, 32'(readyA), 1);

    repeat (600) begin
      applyStimulus(0, ($urandom_range(0, 9) < 7), $urandom);
      runCycle(0);
    end

    @(negedge clk32f);
    resetA = 1'b1;

    // Four-lane instance: striping, then counter wrap at CNT_W=4.
    applyStimulus(1, 1'b1, 32'hCABF_FABC);
    doReset(1);
    repeat (8) runCycle(1);
    checkOutput("b_ready", 1, 32'(readyB), 1);
    startCapture();
    repeat (8) runCycle(1);
    checkOutput("b_lane0", 1, 32'(cap[0][7:0]), 32'hCA);
    checkOutput("b_lane1", 1, 32'(cap[1][7:0]), 32'hBF);
    checkOutput("b_lane2", 1, 32'(cap[2][7:0]), 32'hFA);
    checkOutput("b_lane3", 1, 32'(cap[3][7:0]), 32'hBC);
    checkOutput("b_valid_all", 1, 32'(vAnd), 32'hF);
    checkOutput("b_cnt", 1, 32'(cntB), 1);
    for (int w = 2; w <= 17; w++) begin
      applyStimulus(1, 1'b1, $urandom);
      repeat (8) runCycle(1);
      checkOutput("b_word_cnt", 1, 32'(cntB), w % 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phy_tx_stripe_serializer.md
Name: phy_tx_stripe_serializer

Overview:
Parametrised transmit datapath for the PHY layer. It accepts DATA_W-bit words over a valid/ready handshake and stripes their bytes round-robin across LANES serial lanes, shifting each lane out MSB-first at one bit per clock. A lane is filled with the idle symbol whenever no word is available, and a minimum run of idle frames is forced after reset. It sits between the word-level link logic and the per-lane line drivers, on the single bit-rate clock.

Parameters:
DATA_W, 32, input word width; must be a multiple of 8*LANES.
LANES, 2, number of serial lanes; legal values are 1, 2 and 4.
IDLE_BYTE, 8'hBC, filler byte (K28.5 value) sent on idle frames.
MIN_IDLE, 4, idle frames forced after reset before ready_out may assert; range 0..255.
CNT_W, 16, width of the accepted-word counter.

Ports:
clk_32f  input  1  bit-rate clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  DATA_W  word to transmit; byte 0 is data_in[DATA_W-1 -: 8].
valid_in  input  1  data_in holds a word.
ready_out  output  1  block accepts data_in on this edge.
data_out  output  LANES  serial bit per lane.
valid_out  output  LANES  per-lane flag: current bit belongs to a data frame (all bits equal).
word_cnt  output  CNT_W  count of accepted words, wrapping.

Behaviour:
- Derived values: P = DATA_W/LANES is the frame length in cycles. BPL = DATA_W/(8*LANES) is the number of bytes per lane per frame.
- Striping: byte k goes to lane (k mod LANES) in slot (k div LANES). Slot 0 is shifted first and each byte is sent MSB-first.
- Per-lane shift register is P bits wide. data_out[l] is the register MSB. The register shifts left by 1 every non-boundary cycle.
- bit_cnt runs 0..P-1 and wraps. A frame boundary is the edge where bit_cnt==P-1.
- At a frame boundary each shift register loads either a data frame or an idle frame (IDLE_BYTE repeated BPL times), and bit_cnt goes to 0.
- ready_out = (state==RUN) && (bit_cnt==P-1). It is combinational from registers and asserts exactly 1 cycle per frame.
- Transfer happens on valid_in && ready_out at a boundary edge. The block loads the word, sets valid_out to all-ones and increments word_cnt (wrapping at 2^CNT_W-1 -> 0).
- A boundary edge without a transfer loads an idle frame and sets valid_out to all-zeros.
- Latency: the first bit of an accepted word appears on data_out the cycle after the accepting edge. The last bit appears P cycles after that edge. Back-to-back words stream with no gap.
- valid_in while ready_out=0 is ignored. The upstream holds the word; there is no loss.
- State machine:
  - STARTUP: every boundary loads idle and counts idle frames. After MIN_IDLE idle frames have been loaded it goes to RUN on that same edge.
  - RUN: normal operation; it never leaves RUN except via reset.
- Reset state (asynchronous):
  - state = STARTUP, or RUN when MIN_IDLE==0.
  - shift registers = 0, so data_out = 0.
  - valid_out = 0, word_cnt = 0, idle counter = 0.
  - bit_cnt = P-1, so the first edge after release is a boundary. ready_out = 0, except when MIN_IDLE==0, where ready_out = 1 in the first cycle after release.
- Reset asserted mid-frame aborts the frame immediately with no partial completion. After release the block re-enters STARTUP and sends MIN_IDLE idle frames again.
- LANES==1 degenerates to a plain P-bit serializer with the same rules.

Decomposition:
- Package phy_tx_pkg holds:
  - the K28_5 constant (8'hBC);
  - the state enum {STARTUP, RUN};
  - a function computing P and BPL;
  - an elaboration-time legality check on DATA_W and LANES.
- Sub-module phy_tx_lane_shifter (P-bit load/shift register with MSB output) is instantiated LANES times with generate.
- Top level holds bit_cnt, the FSM, the idle counter, word_cnt and the byte-striping mux.

Test Plan:
1. Reset release, DATA_W=32, LANES=2, MIN_IDLE=4, valid_in=1 held -> ready_out stays 0 for 4 frames (64 cycles). Each lane shows 1011_1100 repeated and valid_out=2'b00. The first ready_out comes on cycle 64 after release.
2. Accept 32'hFFDD_FFDD, then 32'hDDFF_AABB back-to-back:
   - lane0 shows FF,FF, then DD,AA;
   - lane1 shows DD,DD, then FF,BB;
   - valid_out=2'b11 for 32 consecutive cycles with no gap.
3. valid_in drops after one word -> the next frame carries BC,BC on both lanes, valid_out=0 and word_cnt stays at 1. Re-raising valid_in is accepted only at the next ready_out.
4. LANES=4, DATA_W=32, word 32'hCABF_FABC -> in an 8-cycle frame lane0..3 show CA, BF, FA, BC respectively.
5. Assert reset at bit 5 of a data frame -> data_out, valid_out and word_cnt go to 0 immediately. After release, 4 idle frames are sent before ready_out.
6. CNT_W=4, 17 accepted words -> word_cnt goes 15 -> 0 -> 1.
